// File: rtl/psum_accum_sfu.sv
// Multi-pass partial-sum accumulator: sums num_pass passes of depth vectors per lane with
// signed saturation, then drains the buffer through a valid/ready port with optional ReLU.
module psum_accum_sfu #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int depth   = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [3:0]               num_pass,
   input  logic                     relu_en,
   input  logic                     in_valid,
   input  logic [col*psum_bw-1:0]   in_data,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [col*psum_bw-1:0]   out_data,
   input  logic                     out_ready,
   output logic                     busy,
   output logic                     done
);

   localparam int aw = (depth > 1) ? $clog2(depth) : 1;
   localparam int vw = col * psum_bw;
   localparam logic [aw-1:0] last_ptr = aw'(depth - 1);

   typedef enum logic [1:0] {
      st_idle  = 2'd0,
      st_acc   = 2'd1,
      st_drain = 2'd2
   } state_t;

   state_t          state_r;
   state_t          state_s;
   logic [aw-1:0]   wr_ptr_r;
   logic [aw-1:0]   rd_ptr_r;
   logic [3:0]      pass_cnt_r;
   logic [3:0]      last_pass_r;
   logic            relu_r;
   logic            done_r;
   logic [vw-1:0]   buf_r [depth];
   logic [vw-1:0]   old_vec_s;
   logic [vw-1:0]   acc_vec_s;
   logic [vw-1:0]   rd_vec_s;
   logic            in_fire_s;
   logic            out_fire_s;
   logic            last_in_s;
   logic            last_out_s;

   // Widen by one bit so the true sum is exact, then clamp on overflow of the top two bits.
   function automatic logic [psum_bw-1:0] sat_add(input logic [psum_bw-1:0] a,
                                                 input logic [psum_bw-1:0] b);
      logic [psum_bw:0] sum_v;
      sum_v = {a[psum_bw-1], a} + {b[psum_bw-1], b};
      if (sum_v[psum_bw] != sum_v[psum_bw-1]) begin
         if (sum_v[psum_bw]) begin
            sat_add = {1'b1, {(psum_bw-1){1'b0}}};
         end else begin
            sat_add = {1'b0, {(psum_bw-1){1'b1}}};
         end
      end else begin
         sat_add = sum_v[psum_bw-1:0];
      end
   endfunction

   // Handshake qualification and end-of-phase detection.
   always_comb begin
      in_fire_s  = in_valid & (state_r == st_acc);
      out_fire_s = out_ready & (state_r == st_drain);
      last_in_s  = in_fire_s & (wr_ptr_r == last_ptr) & (pass_cnt_r == last_pass_r);
      last_out_s = out_fire_s & (rd_ptr_r == last_ptr);
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= st_idle;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         st_idle: begin
            if (start) begin
               state_s = st_acc;
            end else begin
               state_s = st_idle;
            end
         end
         st_acc: begin
            if (last_in_s) begin
               state_s = st_drain;
            end else begin
               state_s = st_acc;
            end
         end
         st_drain: begin
            if (last_out_s) begin
               state_s = st_idle;
            end else begin
               state_s = st_drain;
            end
         end
         default: state_s = st_idle;
      endcase
   end

   // Output decode; ReLU acts only on the read path so the buffer keeps signed sums.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      out_data  = '0;
      rd_vec_s  = buf_r[rd_ptr_r];
      case (state_r)
         st_idle: begin
            busy = 1'b0;
         end
         st_acc: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         st_drain: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            for (int i = 0; i < col; i++) begin
               if (relu_r && rd_vec_s[i*psum_bw + psum_bw - 1]) begin
                  out_data[i*psum_bw +: psum_bw] = '0;
               end else begin
                  out_data[i*psum_bw +: psum_bw] = rd_vec_s[i*psum_bw +: psum_bw];
               end
            end
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign done = done_r;

   // Per-lane accumulate; pass 0 overwrites so stale contents from earlier jobs never leak.
   always_comb begin
      acc_vec_s = '0;
      old_vec_s = buf_r[wr_ptr_r];
      for (int i = 0; i < col; i++) begin
         if (pass_cnt_r == 4'd0) begin
            acc_vec_s[i*psum_bw +: psum_bw] = in_data[i*psum_bw +: psum_bw];
         end else begin
            acc_vec_s[i*psum_bw +: psum_bw] = sat_add(old_vec_s[i*psum_bw +: psum_bw],
                                                      in_data[i*psum_bw +: psum_bw]);
         end
      end
   end

   // Accumulation buffer write port.
   always_ff @(posedge clk) begin
      if (in_fire_s) begin
         buf_r[wr_ptr_r] <= acc_vec_s;
      end
   end

   // Pointers, pass counter, job configuration and done pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         pass_cnt_r  <= 4'd0;
         last_pass_r <= 4'd0;
         relu_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         done_r <= last_out_s;
         case (state_r)
            st_idle: begin
               if (start) begin
                  wr_ptr_r    <= '0;
                  pass_cnt_r  <= 4'd0;
                  last_pass_r <= (num_pass == 4'd0) ? 4'd0 : (num_pass - 4'd1);
                  relu_r      <= relu_en;
               end
            end
            st_acc: begin
               if (in_fire_s) begin
                  wr_ptr_r <= wr_ptr_r + aw'(1);
                  if (wr_ptr_r == last_ptr) begin
                     pass_cnt_r <= pass_cnt_r + 4'd1;
                  end
                  if (last_in_s) begin
                     rd_ptr_r <= '0;
                  end
               end
            end
            st_drain: begin
               if (out_fire_s) begin
                  rd_ptr_r <= rd_ptr_r + aw'(1);
               end
            end
            default: begin
               rd_ptr_r <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_psum_accum_sfu.sv
// Directed self-checking bench for psum_accum_sfu (col=8, psum_bw=16, depth=16).
module tb_psum_accum_sfu;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [3:0]   num_pass;
   logic         relu_en;
   logic         in_valid;
   logic [127:0] in_data;
   logic         in_ready;
   logic         out_valid;
   logic [127:0] out_data;
   logic         out_ready;
   logic         busy;
   logic         done;

   int n_chk  = 0;
   int n_fail = 0;

   logic [127:0] cur_in  [16];
   logic [127:0] exp_out [16];

   psum_accum_sfu #(.col(8), .psum_bw(16), .depth(16)) dut (
      .clk(clk), .reset(reset), .start(start), .num_pass(num_pass), .relu_en(relu_en),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] splat(input logic [15:0] v);
      return {8{v}};
   endfunction

   task automatic start_job(input logic [3:0] np, input logic relu);
      @(negedge clk);
      start = 1'b1; num_pass = np; relu_en = relu; in_valid = 1'b0;
      #1;
      chk("idle_in_ready", in_ready, 1'b0);
      chk("idle_busy", busy, 1'b0);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("start_busy", busy, 1'b1);
      chk("start_in_ready", in_ready, 1'b1);
   endtask

   task automatic feed_pass(input int gap_pct, input bit pulse_start);
      for (int k = 0; k < 16; k++) begin
         int g = 0;
         while (g < 3 && $urandom_range(99) < gap_pct) begin
            @(negedge clk);
            in_valid = 1'b0; start = pulse_start;
            @(posedge clk);
            g++;
         end
         @(negedge clk);
         in_valid = 1'b1; in_data = cur_in[k]; start = pulse_start;
         #1;
         chk("acc_in_ready", in_ready, 1'b1);
         @(posedge clk);
      end
   endtask

   task automatic drain(input int rdy_pct, input bit poke);
      int idx = 0;
      int cyc = 0;
      bit stalled = 1'b0;
      logic [127:0] held = '0;
      while (idx < 16 && cyc < 400) begin
         @(negedge clk);
         in_valid  = 1'b0;
         out_ready = ($urandom_range(99) < rdy_pct);
         start     = poke && (idx < 8) && (cyc % 3 == 0);
         in_valid  = poke && cyc[0];
         in_data   = splat(16'h1234);
         #1;
         chk("drain_valid", out_valid, 1'b1);
         chk("drain_in_ready", in_ready, 1'b0);
         chk("drain_data", out_data, exp_out[idx]);
         if (stalled) chk("stall_stable", out_data, held);
         stalled = !out_ready;
         held = out_data;
         if (out_ready) idx++;
         cyc++;
         @(posedge clk);
      end
      if (idx < 16) chk("drain_timeout", 128'(idx), 128'd16);
      @(negedge clk);
      out_ready = 1'b0; start = 1'b0; in_valid = 1'b0;
      #1;
      chk("done_pulse", done, 1'b1);
      chk("done_busy", busy, 1'b0);
      chk("done_out_valid", out_valid, 1'b0);
      chk("done_out_data", out_data, 128'd0);
      @(negedge clk);
      #1;
      chk("done_single", done, 1'b0);
      chk("idle_after_done", busy, 1'b0);
   endtask

   task automatic watch_no_done();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         chk("no_done_after_reset", done, 1'b0);
         chk("idle_after_reset", busy, 1'b0);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1'b0);
      chk({tag, "_out_valid"}, out_valid, 1'b0);
      chk({tag, "_out_data"}, out_data, 128'd0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; num_pass = 4'd0; relu_en = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_reset_outputs("reset");

      // Single pass, no ReLU: ramp of small signed values passes straight through.
      for (int k = 0; k < 16; k++)
         for (int i = 0; i < 8; i++) begin
            cur_in[k][i*16 +: 16]  = 16'(k*8 + i - 64);
            exp_out[k][i*16 +: 16] = 16'(k*8 + i - 64);
         end
      start_job(4'd1, 1'b0);
      feed_pass(0, 1'b0);
      drain(100, 1'b0);

      // Three passes of 100, 200, 300.
      start_job(4'd3, 1'b0);
      for (int p = 0; p < 3; p++) begin
         for (int k = 0; k < 16; k++) cur_in[k] = splat(16'(100 * (p + 1)));
         feed_pass(0, 1'b0);
      end
      for (int k = 0; k < 16; k++) exp_out[k] = splat(16'd600);
      drain(100, 1'b0);

      // num_pass = 0 behaves as one pass.
      start_job(4'd0, 1'b0);
      for (int k = 0; k < 16; k++) cur_in[k] = splat(16'd100);
      feed_pass(0, 1'b0);
      for (int k = 0; k < 16; k++) exp_out[k] = splat(16'd100);
      drain(100, 1'b0);

      // Saturation: even lanes 0x7000 twice, odd lanes -20000 (0xB1E0) twice.
      for (int k = 0; k < 16; k++)
         for (int i = 0; i < 8; i++) begin
            cur_in[k][i*16 +: 16]  = (i % 2 == 0) ? 16'h7000 : 16'hB1E0;
            exp_out[k][i*16 +: 16] = (i % 2 == 0) ? 16'h7FFF : 16'h0000;
         end
      start_job(4'd2, 1'b1);
      feed_pass(0, 1'b0);
      feed_pass(0, 1'b0);
      drain(100, 1'b0);
      for (int k = 0; k < 16; k++)
         for (int i = 0; i < 8; i++)
            exp_out[k][i*16 +: 16] = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
      start_job(4'd2, 1'b0);
      feed_pass(0, 1'b0);
      feed_pass(0, 1'b0);
      drain(100, 1'b0);

      // Backpressure: random input gaps and 30% out_ready.
      start_job(4'd2, 1'b0);
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < 16; k++)
            for (int i = 0; i < 8; i++)
               cur_in[k][i*16 +: 16] = 16'((k*16 + i) * (p + 1));
         feed_pass(40, 1'b0);
      end
      for (int k = 0; k < 16; k++)
         for (int i = 0; i < 8; i++)
            exp_out[k][i*16 +: 16] = 16'(3 * (k*16 + i));
      drain(30, 1'b0);

      // Ignored events: in_valid in IDLE, start in ACC/DRAIN, in_valid in DRAIN.
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = splat(16'h5A5A);
         #1;
         chk("idle_ignore_ready", in_ready, 1'b0);
         chk("idle_ignore_busy", busy, 1'b0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 16; k++)
         for (int i = 0; i < 8; i++) begin
            cur_in[k][i*16 +: 16]  = 16'(k*3 - i*7);
            exp_out[k][i*16 +: 16] = 16'(k*3 - i*7);
         end
      start_job(4'd1, 1'b0);
      feed_pass(30, 1'b1);
      drain(70, 1'b1);

      // Reset mid-ACC of a two-pass job.
      start_job(4'd2, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         in_valid = 1'b1; in_data = splat(16'h0777);
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      check_reset_outputs("acc_reset");
      @(negedge clk);
      reset = 1'b0;
      watch_no_done();

      // Reset mid-DRAIN.
      for (int k = 0; k < 16; k++) begin
         cur_in[k]  = splat(16'(2000 + k));
         exp_out[k] = splat(16'(2000 + k));
      end
      start_job(4'd1, 1'b0);
      feed_pass(0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         out_ready = 1'b1;
         #1;
         chk("pre_reset_data", out_data, exp_out[k]);
         @(posedge clk);
      end
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      chk("pre_reset_valid", out_valid, 1'b1);
      #1 reset = 1'b1;
      #1;
      check_reset_outputs("drain_reset");
      @(negedge clk);
      reset = 1'b0;
      watch_no_done();

      // Fresh single-pass job returns only the new data.
      for (int k = 0; k < 16; k++) begin
         cur_in[k]  = splat(16'(1000 + k));
         exp_out[k] = splat(16'(1000 + k));
      end
      start_job(4'd1, 1'b0);
      feed_pass(0, 1'b0);
      drain(100, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
